ct_f_spsram_req_ctrl: RTL

Requester-side controller for the 256x144 single-port SRAM macro (`ct_f_spsram_256x144` class). It converts a valid/ready read/write request stream into the macro's active-low `CEN`/`GWEN`/`WEN` pin protocol. It captures `Q` into a 2-entry response buffer with backpressure and, optionally, zero-initialises every entry after reset. It sits between a cache/buffer pipeline and the SRAM instance it owns.

---
 rtl/ct_f_spsram_req_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ct_f_spsram_req_ctrl.sv
// Requester-side controller for a single-port SRAM macro: valid/ready requests to CEN/GWEN/WEN pins,
// 2-entry response buffer. Define CT_F_SPSRAM_CTRL_INIT_EN to zero-fill the SRAM after reset.
module ct_f_spsram_req_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 144
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] A,
    output logic                  CEN,
    output logic                  GWEN,
    output logic [DATA_WIDTH-1:0] WEN,
    output logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] Q
);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            count_q, count_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] buf_q [2];

    logic                  fire;
    logic                  push;
    logic                  pop;
    logic [2:0]            credit_used;

`ifdef CT_F_SPSRAM_CTRL_INIT_EN
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
`endif

    assign init_done   = (state_q == ST_RUN);
    assign rsp_vld     = (count_q != 2'd0);
    assign rsp_rdata   = buf_q[rd_ptr_q];
    assign pop         = rsp_vld & rsp_rdy;
    assign push        = inflight_q;
    // Slots already promised (in flight or buffered) minus the one leaving this cycle
    assign credit_used = {2'b00, inflight_q} + {1'b0, count_q} - {2'b00, pop};
    assign req_rdy     = init_done & (credit_used < 3'd2);
    assign fire        = req_vld & req_rdy;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_WAIT: begin
`ifdef CT_F_SPSRAM_CTRL_INIT_EN
                state_d = ST_INIT;
`else
                state_d = ST_RUN;
`endif
            end
            ST_INIT: begin
`ifdef CT_F_SPSRAM_CTRL_INIT_EN
                if (&init_cnt_q) begin
                    state_d = ST_RUN;
                end
`else
                state_d = ST_RUN;
`endif
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_WAIT;
        endcase
    end

`ifdef CT_F_SPSRAM_CTRL_INIT_EN
    always_comb begin
        init_cnt_d = init_cnt_q;
        if ((state_q == ST_INIT) && !(&init_cnt_q)) begin
            init_cnt_d = init_cnt_q + 1'b1;
        end
    end
`endif

    always_comb begin
        CEN  = 1'b1;
        GWEN = 1'b1;
        WEN  = '1;
        A    = req_addr;
        D    = req_wdata;
        if (state_q == ST_RUN) begin
            CEN  = ~fire;
            GWEN = ~(fire & req_wr);
            WEN  = fire ? ~req_wmask : '1;
        end
`ifdef CT_F_SPSRAM_CTRL_INIT_EN
        else if (state_q == ST_INIT) begin
            CEN  = 1'b0;
            GWEN = 1'b0;
            WEN  = '0;
            D    = '0;
            A    = init_cnt_q;
        end
`endif
    end

    always_comb begin
        inflight_d = fire & ~req_wr;
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d   = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d   = pop  ? ~rd_ptr_q : rd_ptr_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_WAIT;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

`ifdef CT_F_SPSRAM_CTRL_INIT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            init_cnt_q <= '0;
        end else begin
            init_cnt_q <= init_cnt_d;
        end
    end
`endif

    // Payload storage needs no reset; occupancy is tracked by count_q
    always_ff @(posedge CLK) begin
        if (push) begin
            buf_q[wr_ptr_q] <= Q;
        end
    end

    assert property (@(posedge CLK) disable iff (RST) !(push && (count_q == 2'd2)))
        else $error("response buffer overflow");

endmodule
